// File: rtl/body_state_bank.sv
// rtl/body_state_bank.sv - per-body state store with init sequencer, random R/W port and streaming scan
// Optional macro BODY_SCAN_SKIP_DEAD_EN: scan skips slots whose alive flag is clear.
module body_state_bank #(
    parameter int NUM_BODIES   = 11,
    parameter int IDX_W        = $clog2(NUM_BODIES),
    parameter int POS_W        = 19,
    parameter int RAD_W        = 10,
    parameter int TYPE_W       = 2,
    parameter int DEFAULT_TYPE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3:0]        wr_mask,
    input  logic [POS_W-1:0]  wr_pos_x,
    input  logic [POS_W-1:0]  wr_pos_y,
    input  logic [RAD_W-1:0]  wr_rad,
    input  logic [TYPE_W-1:0] wr_type,
    input  logic              wr_alive,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [POS_W-1:0]  rd_pos_x,
    output logic [POS_W-1:0]  rd_pos_y,
    output logic [RAD_W-1:0]  rd_rad,
    output logic [TYPE_W-1:0] rd_type,
    output logic              rd_alive,
    input  logic              scan_start,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic [IDX_W-1:0]  scan_idx,
    output logic [POS_W-1:0]  scan_pos_x,
    output logic [POS_W-1:0]  scan_pos_y,
    output logic [RAD_W-1:0]  scan_rad,
    output logic [TYPE_W-1:0] scan_type,
    output logic              scan_alive,
    output logic              scan_done
);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] NB      = CNT_W'(NUM_BODIES);
    localparam logic [CNT_W-1:0] NB_LAST = CNT_W'(NUM_BODIES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d;

    logic [POS_W-1:0]  pos_x_mem [NUM_BODIES];
    logic [POS_W-1:0]  pos_y_mem [NUM_BODIES];
    logic [RAD_W-1:0]  rad_mem   [NUM_BODIES];
    logic [TYPE_W-1:0] type_mem  [NUM_BODIES];
    logic              alive_mem [NUM_BODIES];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [3:0]        mem_mask;
    logic [POS_W-1:0]  mem_pos_x, mem_pos_y;
    logic [RAD_W-1:0]  mem_rad;
    logic [TYPE_W-1:0] mem_type;
    logic              mem_alive;

    logic              rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [POS_W-1:0]  rd_pos_x_q, rd_pos_x_d, rd_pos_y_q, rd_pos_y_d;
    logic [RAD_W-1:0]  rd_rad_q, rd_rad_d;
    logic [TYPE_W-1:0] rd_type_q, rd_type_d;
    logic              rd_alive_q, rd_alive_d;

    logic              scan_valid_q, scan_valid_d, scan_done_q, scan_done_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [POS_W-1:0]  scan_pos_x_q, scan_pos_x_d, scan_pos_y_q, scan_pos_y_d;
    logic [RAD_W-1:0]  scan_rad_q, scan_rad_d;
    logic [TYPE_W-1:0] scan_type_q, scan_type_d;
    logic              scan_alive_q, scan_alive_d;

    logic              wr_ok, rd_ok, rd_in_range, wr_hit, load_beat;
    logic [IDX_W-1:0]  scan_slot;
    logic              slot_eligible, beat_alive;

    assign wr_ok       = (state_q != ST_INIT) && wr_en && ({1'b0, wr_idx} < NB);
    assign rd_ok       = (state_q != ST_INIT) && rd_en;
    assign rd_in_range = ({1'b0, rd_idx} < NB);
    assign wr_hit      = wr_ok && (wr_idx == rd_idx);
    assign scan_slot   = ptr_q[IDX_W-1:0];

`ifdef BODY_SCAN_SKIP_DEAD_EN
    assign slot_eligible = alive_mem[scan_slot];
    assign beat_alive    = 1'b1;
`else
    assign slot_eligible = 1'b1;
    assign beat_alive    = alive_mem[scan_slot];
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_we       = 1'b0;
        mem_idx      = '0;
        mem_mask     = '0;
        mem_pos_x    = '0;
        mem_pos_y    = '0;
        mem_rad      = '0;
        mem_type     = '0;
        mem_alive    = 1'b0;
        rd_valid_d   = 1'b0;
        rd_err_d     = 1'b0;
        rd_pos_x_d   = rd_pos_x_q;
        rd_pos_y_d   = rd_pos_y_q;
        rd_rad_d     = rd_rad_q;
        rd_type_d    = rd_type_q;
        rd_alive_d   = rd_alive_q;
        scan_valid_d = scan_valid_q;
        scan_done_d  = 1'b0;
        scan_idx_d   = scan_idx_q;
        scan_pos_x_d = scan_pos_x_q;
        scan_pos_y_d = scan_pos_y_q;
        scan_rad_d   = scan_rad_q;
        scan_type_d  = scan_type_q;
        scan_alive_d = scan_alive_q;
        load_beat    = 1'b0;

        if (wr_ok) begin
            mem_we    = 1'b1;
            mem_idx   = wr_idx;
            mem_mask  = wr_mask;
            mem_pos_x = wr_pos_x;
            mem_pos_y = wr_pos_y;
            mem_rad   = wr_rad;
            mem_type  = wr_type;
            mem_alive = wr_alive;
        end

        // Write-first: a same-slot write in this cycle overrides the stored field.
        if (rd_ok) begin
            rd_valid_d = 1'b1;
            if (rd_in_range) begin
                rd_pos_x_d = (wr_hit && wr_mask[0]) ? wr_pos_x : pos_x_mem[rd_idx];
                rd_pos_y_d = (wr_hit && wr_mask[0]) ? wr_pos_y : pos_y_mem[rd_idx];
                rd_rad_d   = (wr_hit && wr_mask[1]) ? wr_rad   : rad_mem[rd_idx];
                rd_type_d  = (wr_hit && wr_mask[2]) ? wr_type  : type_mem[rd_idx];
                rd_alive_d = (wr_hit && wr_mask[3]) ? wr_alive : alive_mem[rd_idx];
            end else begin
                rd_err_d   = 1'b1;
                rd_pos_x_d = '0;
                rd_pos_y_d = '0;
                rd_rad_d   = '0;
                rd_type_d  = '0;
                rd_alive_d = 1'b0;
            end
        end

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_idx   = ptr_q[IDX_W-1:0];
                mem_mask  = 4'hF;
                mem_type  = TYPE_W'(DEFAULT_TYPE);
                mem_alive = 1'b1;
                if (ptr_q == NB_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end else if (scan_start) begin
                    // Slot 0 is fetched right away so the first beat lands one cycle later.
                    state_d   = ST_SCAN;
                    load_beat = 1'b1;
                end
            end
            ST_SCAN: begin
                if (init_req) begin
                    state_d      = ST_INIT;
                    ptr_d        = '0;
                    scan_valid_d = 1'b0;
                end else if (!scan_valid_q || scan_ready) begin
                    if (ptr_q == NB) begin
                        scan_valid_d = 1'b0;
                        scan_done_d  = 1'b1;
                        state_d      = ST_IDLE;
                        ptr_d        = '0;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase

        if (load_beat) begin
            ptr_d        = ptr_q + 1'b1;
            scan_valid_d = slot_eligible;
            if (slot_eligible) begin
                scan_idx_d   = scan_slot;
                scan_pos_x_d = pos_x_mem[scan_slot];
                scan_pos_y_d = pos_y_mem[scan_slot];
                scan_rad_d   = rad_mem[scan_slot];
                scan_type_d  = type_mem[scan_slot];
                scan_alive_d = beat_alive;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mem_mask[0]) begin
                pos_x_mem[mem_idx] <= mem_pos_x;
                pos_y_mem[mem_idx] <= mem_pos_y;
            end
            if (mem_mask[1]) rad_mem[mem_idx]   <= mem_rad;
            if (mem_mask[2]) type_mem[mem_idx]  <= mem_type;
            if (mem_mask[3]) alive_mem[mem_idx] <= mem_alive;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_pos_x_q   <= '0;
            rd_pos_y_q   <= '0;
            rd_rad_q     <= '0;
            rd_type_q    <= '0;
            rd_alive_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_idx_q   <= '0;
            scan_pos_x_q <= '0;
            scan_pos_y_q <= '0;
            scan_rad_q   <= '0;
            scan_type_q  <= '0;
            scan_alive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_pos_x_q   <= rd_pos_x_d;
            rd_pos_y_q   <= rd_pos_y_d;
            rd_rad_q     <= rd_rad_d;
            rd_type_q    <= rd_type_d;
            rd_alive_q   <= rd_alive_d;
            scan_valid_q <= scan_valid_d;
            scan_done_q  <= scan_done_d;
            scan_idx_q   <= scan_idx_d;
            scan_pos_x_q <= scan_pos_x_d;
            scan_pos_y_q <= scan_pos_y_d;
            scan_rad_q   <= scan_rad_d;
            scan_type_q  <= scan_type_d;
            scan_alive_q <= scan_alive_d;
        end
    end

    assign busy       = (state_q == ST_INIT);
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_pos_x   = rd_pos_x_q;
    assign rd_pos_y   = rd_pos_y_q;
    assign rd_rad     = rd_rad_q;
    assign rd_type    = rd_type_q;
    assign rd_alive   = rd_alive_q;
    assign scan_valid = scan_valid_q;
    assign scan_done  = scan_done_q;
    assign scan_idx   = scan_idx_q;
    assign scan_pos_x = scan_pos_x_q;
    assign scan_pos_y = scan_pos_y_q;
    assign scan_rad   = scan_rad_q;
    assign scan_type  = scan_type_q;
    assign scan_alive = scan_alive_q;

endmodule

// File: doc/body_state_bank.md
Name: body_state_bank

Overview:
- Parametrised per-body state store for the physics engine: position X/Y, radian, type and alive flag for NUM_BODIES bodies.
- It replaces the separate per-field register files and adds:
  - a single random-access write port with a field mask;
  - a registered random read port;
  - a self-clearing init sequencer;
  - a streaming scan engine that feeds the collision and render pipelines one body per cycle, using a valid/ready handshake.

Parameters:
- NUM_BODIES, 11, number of body slots (2..64)
- IDX_W, $clog2(NUM_BODIES), index width
- POS_W, 19, signed fixed-point position width (1 sign, 10 int, 8 frac)
- RAD_W, 10, signed radian width (1 sign, 2 int, 7 frac)
- TYPE_W, 2, body type width (0 static, 1 dynamic, 2 pig)
- DEFAULT_TYPE, 1, type loaded into every slot by init

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-low
- init_req, in, 1, pulse: re-run the init sequence
- busy, out, 1, init in progress
- wr_en, in, 1, write strobe
- wr_idx, in, IDX_W, write slot
- wr_mask, in, 4, field enables: [0] pos X/Y, [1] rad, [2] type, [3] alive
- wr_pos_x / wr_pos_y, in, POS_W each, position data
- wr_rad, in, RAD_W, radian data
- wr_type, in, TYPE_W, type data
- wr_alive, in, 1, alive data
- rd_en, in, 1, read request
- rd_idx, in, IDX_W, read slot
- rd_valid, out, 1, read data valid
- rd_err, out, 1, read index out of range
- rd_pos_x / rd_pos_y, out, POS_W each, read position
- rd_rad, out, RAD_W, read radian
- rd_type, out, TYPE_W, read type
- rd_alive, out, 1, read alive flag
- scan_start, in, 1, begin a scan
- scan_valid, out, 1, scan beat valid
- scan_ready, in, 1, consumer accepts the current beat
- scan_idx, out, IDX_W, slot index of the current beat
- scan_pos_x / scan_pos_y, out, POS_W each, beat position
- scan_rad, out, RAD_W, beat radian
- scan_type, out, TYPE_W, beat type
- scan_alive, out, 1, beat alive flag
- scan_done, out, 1, one-cycle pulse at scan end

Behaviour:
- FSM states: INIT, IDLE, SCAN.
- Reset (rst low), asynchronous:
  - state=INIT, init pointer=0, busy=1.
  - rd_valid, rd_err, scan_valid, scan_done=0.
  - All data outputs=0.
  - Storage arrays are not reset; INIT clears them.
- INIT:
  - Each cycle writes slot p: pos=0, rad=0, type=DEFAULT_TYPE, alive=1; then p++.
  - Lasts exactly NUM_BODIES cycles, then goes to IDLE; busy drops in the cycle IDLE is entered.
  - wr_en, rd_en, scan_start and init_req are ignored during INIT.
- init_req:
  - In IDLE: enter INIT with p=0.
  - In SCAN: abort the scan. scan_valid drops next cycle, no scan_done, enter INIT.
- Write:
  - Accepted in IDLE and SCAN when wr_en=1 and wr_idx<NUM_BODIES; takes effect at the next edge.
  - Only fields with their wr_mask bit set change.
  - wr_idx>=NUM_BODIES: write dropped.
- Read:
  - rd_en accepted in IDLE and SCAN; results are registered, so data and rd_valid appear 1 cycle later.
  - rd_valid=0 on cycles with no accepted read; data outputs then hold their last value.
  - Write-first: if wr_en and rd_en target the same in-range slot in the same cycle, the read returns the merged (new) fields.
  - rd_idx>=NUM_BODIES: rd_valid=1, rd_err=1, all data 0.
- Scan:
  - scan_start is honoured only in IDLE. Scan pointer s=0, enter SCAN.
  - Single output register stage. When it is empty, or holds a beat being accepted (scan_valid && scan_ready), slot s is loaded (if eligible) and s advances. Ineligible slots cost one cycle each.
  - First beat: scan_valid at the earliest 1 cycle after scan_start.
  - Throughput: 1 beat/cycle with scan_ready held high.
  - While scan_valid && !scan_ready, all scan_* outputs hold stable.
  - Beat contents are array values at load time. A write to a slot already loaded is not reflected in that beat.
  - End of scan: s==NUM_BODIES and the output register is empty or being accepted. Then scan_done pulses 1 cycle, scan_valid=0 and the FSM goes to IDLE.
  - Concurrent read and write are allowed during SCAN.

Optional Feature:
- Macro: BODY_SCAN_SKIP_DEAD_EN.
- Defined: slots with alive=0 are ineligible and never emitted. scan_alive is always 1. If no slot is alive, scan_done pulses with zero beats, NUM_BODIES+1 cycles after scan_start.
- Undefined: every slot is eligible and scan_alive carries the stored flag.

Test Plan:
- Release reset with default params -> busy=1 for 11 cycles, then 0. Read idx 3 -> rd_valid=1 next cycle, pos=0, rad=0, type=1, alive=1.
- Write idx 2 with mask=4'b0001, pos=(450<<8, 390<<8), rad=0x7F, type=2 -> reading idx 2 returns new pos, rad=0, type=1 (unmasked fields unchanged).
- Same-cycle write idx 5 pos_x=0x12300 and read idx 5 -> read returns 0x12300. Read idx 12 -> rd_valid=1, rd_err=1, data 0.
- Scan with scan_ready=1 -> 11 beats, idx 0..10, on consecutive cycles, then a scan_done pulse. With scan_ready=0 for 3 cycles at beat 4 -> idx 4 and its data held stable, no beat lost.
- BODY_SCAN_SKIP_DEAD_EN defined, idx 1 and 7 killed via mask 4'b1000 -> scan emits 9 beats and skips 1 and 7. With all slots dead -> zero beats, scan_done 12 cycles after scan_start.
- init_req mid-scan after beat 3 -> scan_valid=0 next cycle, no scan_done, busy=1 for 11 cycles. Pulse rst low mid-INIT -> busy stays 1 and init restarts at slot 0.
